param_cacheline_adaptor: RTL and testbench

Parametrised successor to the fixed 256b/64b cacheline adaptor. It converts one cacheline read or write from the cache side into a multi-beat burst transaction on the memory side. Line width, burst width and address width are generic. It adds per-byte write masks, so partial-line writebacks carry byte enables on every beat. It sits between the cache datapath and the physical memory model or arbiter.

---
 rtl/param_cacheline_adaptor_pkg.sv | 21 ++
 rtl/param_cacheline_adaptor_beat_slicer.sv | 18 +
 rtl/param_cacheline_adaptor.sv | 155 +++++++++++++++
 tb/tb_param_cacheline_adaptor.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_cacheline_adaptor_pkg.sv
// Shared types and defaults for the parametrised cacheline adaptor.
// Holds the FSM state enum, default widths and the beat-index width helper.
package cacheline_adaptor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam int DEF_LINE_WIDTH  = 256;
    localparam int DEF_BURST_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH  = 32;

    // log2(beats), never narrower than one bit.
    function automatic int beat_idx_width(input int beats);
        return (beats > 2) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/param_cacheline_adaptor_beat_slicer.sv
// Selects one burst-wide slice of a cacheline and its byte enables.
// Ports: line/mask (full line + byte mask), idx (beat), burst/burst_mask (slice).
module beat_slicer #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int IDX_W       = 2
) (
    input  logic [LINE_WIDTH-1:0]    line,
    input  logic [LINE_WIDTH/8-1:0]  mask,
    input  logic [IDX_W-1:0]         idx,
    output logic [BURST_WIDTH-1:0]   burst,
    output logic [BURST_WIDTH/8-1:0] burst_mask
);

    assign burst      = line[idx * BURST_WIDTH +: BURST_WIDTH];
    assign burst_mask = mask[idx * (BURST_WIDTH / 8) +: BURST_WIDTH / 8];

endmodule

// File: rtl/param_cacheline_adaptor.sv
// Converts a single cacheline read/write into a multi-beat memory burst.
// Ports: cache side (line_i/mask_i/line_o/address_i/read_i/write_i/resp_o),
// memory side (burst_i/burst_o/burst_mask_o/address_o/read_o/write_o/resp_i).
module param_cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [LINE_WIDTH-1:0]      line_i,
    input  logic [LINE_WIDTH/8-1:0]    mask_i,
    output logic [LINE_WIDTH-1:0]      line_o,
    input  logic [ADDR_WIDTH-1:0]      address_i,
    input  logic                       read_i,
    input  logic                       write_i,
    output logic                       resp_o,
    input  logic [BURST_WIDTH-1:0]     burst_i,
    output logic [BURST_WIDTH-1:0]     burst_o,
    output logic [BURST_WIDTH/8-1:0]   burst_mask_o,
    output logic [ADDR_WIDTH-1:0]      address_o,
    output logic                       read_o,
    output logic                       write_o,
    input  logic                       resp_i
);

    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W       = beat_idx_width(BEATS);
    localparam int MASK_W      = LINE_WIDTH / 8;
    localparam int BMASK_W     = BURST_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    if ((LINE_WIDTH % BURST_WIDTH) != 0 || (BURST_WIDTH % 8) != 0 ||
        BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_param_check
        $error("param_cacheline_adaptor: BEATS must be a power of 2 >= 2");
    end

    state_e                  state_q;
    state_e                  state_d;
    logic [IDX_W-1:0]        beat_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_WIDTH-1:0]   wr_line_q;
    logic [MASK_W-1:0]       wr_mask_q;
    logic [LINE_WIDTH-1:0]   rd_buf_q;
    logic [ADDR_WIDTH-1:0]   addr_aligned;
    logic                    last_beat;
    logic [BURST_WIDTH-1:0]  slice_burst;
    logic [BMASK_W-1:0]      slice_mask;

    assign addr_aligned = address_i & ~OFFSET_MASK;
    assign last_beat    = resp_i && (beat_q == LAST_IDX);
    assign address_o    = addr_q;

    beat_slicer #(
        .LINE_WIDTH  (LINE_WIDTH),
        .BURST_WIDTH (BURST_WIDTH),
        .IDX_W       (IDX_W)
    ) u_beat_slicer (
        .line       (wr_line_q),
        .mask       (wr_mask_q),
        .idx        (beat_q),
        .burst      (slice_burst),
        .burst_mask (slice_mask)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read takes priority when both requests arrive together.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (read_i) begin
                    state_d = ST_READ;
                end else if (write_i) begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        read_o       = (state_q == ST_READ);
        write_o      = (state_q == ST_WRITE);
        resp_o       = (state_q == ST_DONE);
        burst_o      = '0;
        burst_mask_o = '0;
        if (state_q == ST_WRITE) begin
            burst_o      = slice_burst;
            burst_mask_o = slice_mask;
        end
    end

    // Beats gather into rd_buf_q; line_o only updates once the
    // final beat lands, so it never exposes a partial line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat_q    <= '0;
            addr_q    <= '0;
            wr_line_q <= '0;
            wr_mask_q <= '0;
            rd_buf_q  <= '0;
            line_o    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (read_i) begin
                        addr_q <= addr_aligned;
                    end else if (write_i) begin
                        addr_q    <= addr_aligned;
                        wr_line_q <= line_i;
                        wr_mask_q <= mask_i;
                    end
                end
                ST_READ: begin
                    if (resp_i) begin
                        rd_buf_q[beat_q * BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == LAST_IDX) begin
                            line_o <= {burst_i,
                                       rd_buf_q[LINE_WIDTH-BURST_WIDTH-1:0]};
                        end
                    end
                end
                ST_WRITE: begin
                    if (resp_i) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                ST_DONE: beat_q <= '0;
                default: beat_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_param_cacheline_adaptor.sv
// Self-checking bench for param_cacheline_adaptor over three width configs.
// A transaction-level model is compared against the DUT on every cycle.
module tb_param_cacheline_adaptor;

    localparam int NCFG = 3;

    logic clk = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    always #5 clk = ~clk;

    task automatic chk(input int cfg, input string nm,
                       input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL c%0d %s: got %0h, expected %0h", cfg, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int LW    = (g == 1) ? 512 : (g == 2) ? 128 : 256;
        localparam int BW    = (g == 1) ? 128 : (g == 2) ? 32 : 64;
        localparam int BEATS = LW / BW;
        localparam int MW    = LW / 8;
        localparam int BMW   = BW / 8;
        // 0x1234_567F aligned to 64, 32 and 16 byte lines.
        localparam logic [31:0] EXP_ALIGN = (g == 1) ? 32'h1234_5640 :
                                            (g == 2) ? 32'h1234_5670 :
                                                       32'h1234_5660;

        logic          reset_n;
        logic [LW-1:0] line_i;
        logic [MW-1:0] mask_i;
        logic [LW-1:0] line_o;
        logic [31:0]   address_i;
        logic          read_i;
        logic          write_i;
        logic          resp_o;
        logic [BW-1:0] burst_i;
        logic [BW-1:0] burst_o;
        logic [BMW-1:0] burst_mask_o;
        logic [31:0]   address_o;
        logic          read_o;
        logic          write_o;
        logic          resp_i;

        param_cacheline_adaptor #(
            .LINE_WIDTH  (LW),
            .BURST_WIDTH (BW),
            .ADDR_WIDTH  (32)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .line_i       (line_i),
            .mask_i       (mask_i),
            .line_o       (line_o),
            .address_i    (address_i),
            .read_i       (read_i),
            .write_i      (write_i),
            .resp_o       (resp_o),
            .burst_i      (burst_i),
            .burst_o      (burst_o),
            .burst_mask_o (burst_mask_o),
            .address_o    (address_o),
            .read_o       (read_o),
            .write_o      (write_o),
            .resp_i       (resp_i)
        );

        // Transaction-level model: phase 0 idle, 1 bursting, 2 responding.
        int            ph = 0;
        bit            rd = 1'b0;
        int            cnt = 0;
        bit            m_live = 1'b0;
        logic [31:0]   m_addr;
        logic [LW-1:0] m_line;
        logic [LW-1:0] m_wline;
        logic [MW-1:0] m_wmask;
        logic [BW-1:0] q[$];

        always @(negedge clk) begin
            if (m_live) begin
                chk(g, "read_o", 512'(read_o), 512'(ph == 1 && rd));
                chk(g, "write_o", 512'(write_o), 512'(ph == 1 && !rd));
                chk(g, "resp_o", 512'(resp_o), 512'(ph == 2));
                chk(g, "address_o", 512'(address_o), 512'(m_addr));
                chk(g, "line_o", 512'(line_o), 512'(m_line));
                chk(g, "rd_wr_excl", 512'(read_o & write_o), 512'(0));
                if (ph == 1 && !rd) begin
                    chk(g, "burst_o", 512'(burst_o),
                        512'(m_wline[cnt*BW +: BW]));
                    chk(g, "burst_mask_o", 512'(burst_mask_o),
                        512'(m_wmask[cnt*BMW +: BMW]));
                end
            end
            if (!reset_n) begin
                ph = 0;
                cnt = 0;
                m_addr = '0;
                m_line = '0;
                q.delete();
                m_live = 1'b1;
            end else begin
                case (ph)
                    0: begin
                        if (read_i || write_i) begin
                            ph = 1;
                            rd = read_i;
                            cnt = 0;
                            m_addr = address_i & ~32'(LW / 8 - 1);
                            q.delete();
                            if (!read_i) begin
                                m_wline = line_i;
                                m_wmask = mask_i;
                            end
                        end
                    end
                    1: begin
                        if (resp_i) begin
                            if (rd) q.push_back(burst_i);
                            cnt++;
                            if (cnt == BEATS) begin
                                ph = 2;
                                if (rd) begin
                                    for (int j = 0; j < BEATS; j++)
                                        m_line[j*BW +: BW] = q[j];
                                end
                            end
                        end
                    end
                    default: begin
                        ph = 0;
                        cnt = 0;
                    end
                endcase
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        function automatic logic [LW-1:0] rand_line();
            logic [LW-1:0] v;
            for (int c = 0; c < LW / 32; c++) v[c*32 +: 32] = $urandom;
            return v;
        endfunction

        function automatic logic [BW-1:0] rand_beat();
            logic [BW-1:0] v;
            for (int c = 0; c < BW / 32; c++) v[c*32 +: 32] = $urandom;
            return v;
        endfunction

        task automatic serve(input int maxstall);
            for (int j = 0; j < BEATS; j++) begin
                repeat ($urandom_range(0, maxstall)) begin
                    resp_i = 1'b0;
                    tick();
                end
                burst_i = rand_beat();
                resp_i = 1'b1;
                tick();
            end
            resp_i = 1'b0;
        endtask

        logic [LW-1:0] exp_line;
        logic [LW-1:0] wline;
        int            pat[6];
        int            nb;
        int            kind;
        bit            hold;

        initial begin : stim
            reset_n = 1'b0;
            read_i = 1'b1;
            write_i = 1'b0;
            resp_i = 1'b0;
            address_i = 32'h1234_567F;
            line_i = '0;
            mask_i = '0;
            burst_i = '0;
            repeat (10) begin
                tick();
                chk(g, "rst read_o", 512'(read_o), 512'(0));
                chk(g, "rst write_o", 512'(write_o), 512'(0));
                chk(g, "rst resp_o", 512'(resp_o), 512'(0));
            end
            read_i = 1'b0;
            reset_n = 1'b1;
            tick();
            chk(g, "post-rst idle", 512'(read_o), 512'(0));

            // Directed read: 20-cycle stall then 0x11.., 0x22.., ...
            read_i = 1'b1;
            tick();
            read_i = 1'b0;
            repeat (20) begin
                chk(g, "stall address_o", 512'(address_o), 512'(EXP_ALIGN));
                chk(g, "stall read_o", 512'(read_o), 512'(1));
                tick();
            end
            for (int j = 0; j < BEATS; j++) begin
                for (int b = 0; b < BMW; b++) begin
                    burst_i[b*8 +: 8] = 8'((j + 1) * 17);
                    exp_line[j*BW + b*8 +: 8] = 8'((j + 1) * 17);
                end
                resp_i = 1'b1;
                tick();
            end
            resp_i = 1'b0;
            chk(g, "dir read resp_o", 512'(resp_o), 512'(1));
            chk(g, "dir read line_o", 512'(line_o), 512'(exp_line));
            tick();
            chk(g, "dir read resp once", 512'(resp_o), 512'(0));

            // Directed masked write: even beats enabled, gapped accepts.
            wline = rand_line();
            line_i = wline;
            for (int j = 0; j < BEATS; j++)
                mask_i[j*BMW +: BMW] = (j % 2 == 0) ? {BMW{1'b1}} : {BMW{1'b0}};
            address_i = $urandom;
            write_i = 1'b1;
            tick();
            write_i = 1'b0;
            pat = '{1, 0, 1, 1, 0, 1};
            nb = 0;
            for (int i = 0; i < 6; i++) begin
                resp_i = pat[i][0];
                #1;
                if (pat[i] == 1) begin
                    chk(g, "dir wr mask", 512'(burst_mask_o),
                        512'((nb % 2 == 0) ? {BMW{1'b1}} : {BMW{1'b0}}));
                    chk(g, "dir wr data", 512'(burst_o),
                        512'(wline[nb*BW +: BW]));
                    nb++;
                end
                tick();
            end
            resp_i = 1'b0;
            chk(g, "dir wr resp_o", 512'(resp_o), 512'(1));
            chk(g, "dir wr write_o", 512'(write_o), 512'(0));
            tick();
            chk(g, "dir wr resp once", 512'(resp_o), 512'(0));

            // Reset in the middle of a read burst.
            address_i = $urandom;
            read_i = 1'b1;
            tick();
            read_i = 1'b0;
            repeat (2) begin
                burst_i = rand_beat();
                resp_i = 1'b1;
                tick();
            end
            resp_i = 1'b0;
            reset_n = 1'b0;
            tick();
            chk(g, "midrst read_o", 512'(read_o), 512'(0));
            chk(g, "midrst resp_o", 512'(resp_o), 512'(0));
            chk(g, "midrst line_o", 512'(line_o), 512'(0));
            reset_n = 1'b1;
            tick();
            read_i = 1'b1;
            tick();
            read_i = 1'b0;
            serve(2);
            chk(g, "after midrst resp_o", 512'(resp_o), 512'(1));
            tick();

            // Simultaneous read and write requests: read wins.
            line_i = rand_line();
            address_i = $urandom;
            read_i = 1'b1;
            write_i = 1'b1;
            tick();
            read_i = 1'b0;
            write_i = 1'b0;
            chk(g, "both read_o", 512'(read_o), 512'(1));
            chk(g, "both write_o", 512'(write_o), 512'(0));
            serve(1);
            chk(g, "both resp_o", 512'(resp_o), 512'(1));
            tick();

            // Random transactions; requests sometimes held until resp_o.
            for (int t = 0; t < 100; t++) begin
                kind = $urandom_range(0, 2);
                hold = 1'($urandom_range(0, 1));
                address_i = $urandom;
                line_i = rand_line();
                for (int i = 0; i < MW; i++) mask_i[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) mask_i = '0;
                read_i = (kind != 1);
                write_i = (kind != 0);
                tick();
                if (!hold) begin
                    read_i = 1'b0;
                    write_i = 1'b0;
                end
                serve(3);
                chk(g, "rand resp_o", 512'(resp_o), 512'(1));
                read_i = 1'b0;
                write_i = 1'b0;
                tick();
                repeat ($urandom_range(0, 2)) tick();
            end
            n_done++;
        end
    end

    initial begin
        wait (n_done == NCFG);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete, n_done=%0d", n_done);
        $fatal(1);
    end

endmodule
